// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin frame arbiter feeding one 64-bit UDP TX port
// Optional stall watchdog with abort beat and DRAIN state: define UDP_TX_ARB_WATCHDOG_EN.
module udp_tx_arbiter #(
    parameter int N           = 4,
    parameter int DEFAULT_TTL = 64,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       local_ip,
    input  logic [N-1:0]      s_hdr_valid,
    output logic [N-1:0]      s_hdr_ready,
    input  logic [N*32-1:0]   s_dest_ip,
    input  logic [N*16-1:0]   s_source_port,
    input  logic [N*16-1:0]   s_dest_port,
    input  logic [N*16-1:0]   s_length,
    input  logic [N*64-1:0]   s_tdata,
    input  logic [N*8-1:0]    s_tkeep,
    input  logic [N-1:0]      s_tvalid,
    input  logic [N-1:0]      s_tlast,
    input  logic [N-1:0]      s_tuser,
    output logic [N-1:0]      s_tready,
    output logic              m_udp_hdr_valid,
    input  logic              m_udp_hdr_ready,
    output logic [5:0]        m_udp_ip_dscp,
    output logic [1:0]        m_udp_ip_ecn,
    output logic [7:0]        m_udp_ip_ttl,
    output logic [31:0]       m_udp_ip_source_ip,
    output logic [31:0]       m_udp_ip_dest_ip,
    output logic [15:0]       m_udp_source_port,
    output logic [15:0]       m_udp_dest_port,
    output logic [15:0]       m_udp_length,
    output logic [15:0]       m_udp_checksum,
    output logic [63:0]       m_udp_payload_axis_tdata,
    output logic [7:0]        m_udp_payload_axis_tkeep,
    output logic              m_udp_payload_axis_tvalid,
    input  logic              m_udp_payload_axis_tready,
    output logic              m_udp_payload_axis_tlast,
    output logic              m_udp_payload_axis_tuser,
    output logic [N-1:0]      grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_config
        // Unsupported configuration: no logic is generated here.
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD
`ifdef UDP_TX_ARB_WATCHDOG_EN
        , ST_DRAIN
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [31:0]   dest_ip_q, dest_ip_d;
    logic [15:0]   src_port_q, src_port_d;
    logic [15:0]   dst_port_q, dst_port_d;
    logic [15:0]   length_q, length_d;
`ifdef UDP_TX_ARB_WATCHDOG_EN
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW:0]   scan_idx;
    logic [PW:0]   rr_inc;
    logic [PW-1:0] rr_next;

    logic          own_tvalid;
    logic          own_tlast;
    logic          own_tuser;
    logic [63:0]   own_tdata;
    logic [7:0]    own_tkeep;

    // Search starts at rr_ptr and wraps explicitly, so N need not be a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(N)) begin
                scan_idx = scan_idx - (PW+1)'(N);
            end
            if (!pick_found && s_hdr_valid[scan_idx[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        rr_inc  = {1'b0, owner_q} + (PW+1)'(1);
        rr_next = (rr_inc >= (PW+1)'(N)) ? '0 : rr_inc[PW-1:0];
    end

    always_comb begin
        own_tvalid = s_tvalid[owner_q];
        own_tlast  = s_tlast[owner_q];
        own_tuser  = s_tuser[owner_q];
        own_tdata  = s_tdata[64*int'(owner_q) +: 64];
        own_tkeep  = s_tkeep[8*int'(owner_q) +: 8];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        dest_ip_d  = dest_ip_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        length_d   = length_q;
`ifdef UDP_TX_ARB_WATCHDOG_EN
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = 1'b0;
`endif
        s_hdr_ready               = '0;
        s_tready                  = '0;
        m_udp_hdr_valid           = 1'b0;
        m_udp_payload_axis_tvalid = 1'b0;
        m_udp_payload_axis_tdata  = '0;
        m_udp_payload_axis_tkeep  = '0;
        m_udp_payload_axis_tlast  = 1'b0;
        m_udp_payload_axis_tuser  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    s_hdr_ready[pick_idx] = 1'b1;
                    owner_d               = pick_idx;
                    grant_d               = '0;
                    grant_d[pick_idx]     = 1'b1;
                    dest_ip_d             = s_dest_ip[32*int'(pick_idx) +: 32];
                    src_port_d            = s_source_port[16*int'(pick_idx) +: 16];
                    dst_port_d            = s_dest_port[16*int'(pick_idx) +: 16];
                    length_d              = s_length[16*int'(pick_idx) +: 16];
                    state_d               = ST_HDR;
                end
            end
            ST_HDR: begin
                m_udp_hdr_valid = 1'b1;
                if (m_udp_hdr_ready) begin
`ifdef UDP_TX_ARB_WATCHDOG_EN
                    stall_cnt_d = '0;
`endif
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
`ifdef UDP_TX_ARB_WATCHDOG_EN
                if (stall_cnt_q == 16'(TIMEOUT)) begin
                    // Owner went quiet: terminate the frame downstream with an errored last beat.
                    m_udp_payload_axis_tvalid = 1'b1;
                    m_udp_payload_axis_tlast  = 1'b1;
                    m_udp_payload_axis_tuser  = 1'b1;
                    m_udp_payload_axis_tkeep  = 8'h01;
                    if (m_udp_payload_axis_tready) begin
                        timeout_err_d = 1'b1;
                        stall_cnt_d   = '0;
                        state_d       = ST_DRAIN;
                    end
                end else begin
`endif
                    m_udp_payload_axis_tvalid = own_tvalid;
                    m_udp_payload_axis_tdata  = own_tdata;
                    m_udp_payload_axis_tkeep  = own_tkeep;
                    m_udp_payload_axis_tlast  = own_tlast;
                    m_udp_payload_axis_tuser  = own_tuser;
                    s_tready[owner_q]         = m_udp_payload_axis_tready;
                    if (own_tvalid && m_udp_payload_axis_tready) begin
`ifdef UDP_TX_ARB_WATCHDOG_EN
                        stall_cnt_d = '0;
`endif
                        if (own_tlast) begin
                            state_d  = ST_IDLE;
                            grant_d  = '0;
                            rr_ptr_d = rr_next;
                        end
                    end
`ifdef UDP_TX_ARB_WATCHDOG_EN
                    else if (!own_tvalid) begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end
                end
`endif
            end
`ifdef UDP_TX_ARB_WATCHDOG_EN
            ST_DRAIN: begin
                s_tready[owner_q] = 1'b1;
                if (own_tvalid && own_tlast) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = rr_next;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            dest_ip_q  <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            length_q   <= '0;
`ifdef UDP_TX_ARB_WATCHDOG_EN
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            dest_ip_q  <= dest_ip_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            length_q   <= length_d;
`ifdef UDP_TX_ARB_WATCHDOG_EN
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign m_udp_ip_dscp      = 6'd0;
    assign m_udp_ip_ecn       = 2'd0;
    assign m_udp_ip_ttl       = 8'(DEFAULT_TTL);
    assign m_udp_ip_source_ip = local_ip;
    assign m_udp_ip_dest_ip   = dest_ip_q;
    assign m_udp_source_port  = src_port_q;
    assign m_udp_dest_port    = dst_port_q;
    assign m_udp_length       = length_q;
    assign m_udp_checksum     = 16'd0;
    assign grant              = grant_q;
    assign busy               = (state_q != ST_IDLE);

`ifdef UDP_TX_ARB_WATCHDOG_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - scoreboard bench for udp_tx_arbiter
module tb_udp_tx_arbiter;

    localparam int          N          = 4;
    localparam int          TB_TIMEOUT = 16;
    localparam logic [31:0] LOCAL_IP   = 32'h0A00_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_tvalid, s_tlast, s_tuser, s_tready;
    logic [N*32-1:0] s_dest_ip;
    logic [N*16-1:0] s_source_port, s_dest_port, s_length;
    logic [N*64-1:0] s_tdata;
    logic [N*8-1:0]  s_tkeep;
    logic            m_udp_hdr_valid, m_udp_hdr_ready;
    logic [5:0]      m_udp_ip_dscp;
    logic [1:0]      m_udp_ip_ecn;
    logic [7:0]      m_udp_ip_ttl;
    logic [31:0]     m_udp_ip_source_ip, m_udp_ip_dest_ip;
    logic [15:0]     m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tvalid, m_tready, m_tlast, m_tuser;
    logic [N-1:0]    grant;
    logic            busy, timeout_err;

    logic        hv[N], tv[N], tl[N], tu[N];
    logic [31:0] dip[N];
    logic [15:0] sp[N], dp[N], ln[N];
    logic [63:0] td[N];
    logic [7:0]  tk[N];
    logic        kill;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign s_hdr_valid[gi]            = hv[gi];
        assign s_dest_ip[32*gi +: 32]     = dip[gi];
        assign s_source_port[16*gi +: 16] = sp[gi];
        assign s_dest_port[16*gi +: 16]   = dp[gi];
        assign s_length[16*gi +: 16]      = ln[gi];
        assign s_tdata[64*gi +: 64]       = td[gi];
        assign s_tkeep[8*gi +: 8]         = tk[gi];
        assign s_tvalid[gi]               = tv[gi];
        assign s_tlast[gi]                = tl[gi];
        assign s_tuser[gi]                = tu[gi];
    end

    udp_tx_arbiter #(.N(N), .DEFAULT_TTL(64), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .local_ip(LOCAL_IP),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_dest_ip(s_dest_ip), .s_source_port(s_source_port),
        .s_dest_port(s_dest_port), .s_length(s_length),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tready(s_tready),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_udp_ip_dscp(m_udp_ip_dscp), .m_udp_ip_ecn(m_udp_ip_ecn),
        .m_udp_ip_ttl(m_udp_ip_ttl), .m_udp_ip_source_ip(m_udp_ip_source_ip),
        .m_udp_ip_dest_ip(m_udp_ip_dest_ip), .m_udp_source_port(m_udp_source_port),
        .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
        .m_udp_checksum(m_udp_checksum),
        .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
        .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
        .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [31:0] dip;
        logic [15:0] sp, dp, len;
        logic [N-1:0] gnt;
    } hdr_t;
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last, user;
    } beat_t;

    hdr_t  hdr_q[$];
    beat_t beat_q[$];
    int    checks = 0;
    int    errors = 0;
    int    nbeats = 0;
    int    tmo_pulses = 0;
    int    abort_gap = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int i, input int b, input logic [15:0] seed);
        return {seed, 16'hBEEF, 16'(i), 16'(b)};
    endfunction

    task automatic expect_frame(input int i, input logic [31:0] d, input logic [15:0] s,
                                input logic [15:0] p, input logic [15:0] l, input int nb,
                                input logic [7:0] lk, input logic [15:0] seed, input int upto);
        logic [N-1:0] g;
        g = '0;
        g[i] = 1'b1;
        hdr_q.push_back('{dip: d, sp: s, dp: p, len: l, gnt: g});
        for (int b = 0; b < upto; b++) begin
            beat_q.push_back('{data: beat_data(i, b, seed),
                               keep: (b == nb - 1) ? lk : 8'hFF,
                               last: (b == nb - 1), user: 1'b0});
        end
    endtask

    task automatic send_frame(input int i, input logic [31:0] d, input logic [15:0] s,
                              input logic [15:0] p, input logic [15:0] l, input int nb,
                              input logic [7:0] lk, input logic [15:0] seed, input int stall_at);
        int n;
        dip[i] = d; sp[i] = s; dp[i] = p; ln[i] = l;
        hv[i] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (kill) begin hv[i] = 1'b0; return; end
            if (s_hdr_ready[i]) break;
            if (++n > 200) begin
                check("hdr_wait_timeout", 64'(s_hdr_ready[i]), 64'd1);
                hv[i] = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        hv[i] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b == stall_at) begin
                tv[i] = 1'b0;
                repeat (24) @(posedge clk);
                #1;
            end
            td[i] = beat_data(i, b, seed);
            tk[i] = (b == nb - 1) ? lk : 8'hFF;
            tl[i] = (b == nb - 1);
            tv[i] = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (kill) begin tv[i] = 1'b0; tl[i] = 1'b0; return; end
                if (s_tready[i]) break;
                if (++n > 200) begin
                    check("beat_wait_timeout", 64'(s_tready[i]), 64'd1);
                    tv[i] = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        tv[i] = 1'b0;
        tl[i] = 1'b0;
    endtask

    initial begin : monitor
        hdr_t  h;
        beat_t bt;
        int    cyc, last_beat_cyc;
        logic  in_frame;
        cyc = 0; last_beat_cyc = 0; in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (m_udp_hdr_valid) begin
                    if (hdr_q.size() == 0) begin
                        check("hdr_unexpected", 64'(m_udp_hdr_valid), 64'd0);
                    end else begin
                        h = hdr_q[0];
                        check("hdr_dest_ip", 64'(m_udp_ip_dest_ip), 64'(h.dip));
                        check("hdr_src_port", 64'(m_udp_source_port), 64'(h.sp));
                        check("hdr_dst_port", 64'(m_udp_dest_port), 64'(h.dp));
                        check("hdr_length", 64'(m_udp_length), 64'(h.len));
                        check("hdr_checksum", 64'(m_udp_checksum), 64'd0);
                        check("hdr_ttl", 64'(m_udp_ip_ttl), 64'd64);
                        check("hdr_dscp_ecn", 64'({m_udp_ip_dscp, m_udp_ip_ecn}), 64'd0);
                        check("hdr_src_ip", 64'(m_udp_ip_source_ip), 64'(LOCAL_IP));
                        check("hdr_grant", 64'(grant), 64'(h.gnt));
                        check("tready_in_hdr", 64'(s_tready), 64'd0);
                        if (m_udp_hdr_ready) begin
                            void'(hdr_q.pop_front());
                            in_frame = 1'b1;
                        end
                    end
                end
                if (m_tvalid && m_tready) begin
                    check("beat_after_hdr", 64'(in_frame), 64'd1);
                    if (beat_q.size() == 0) begin
                        check("beat_unexpected", 64'(m_tvalid), 64'd0);
                    end else begin
                        bt = beat_q.pop_front();
                        check("beat_data", m_tdata, bt.data);
                        check("beat_keep", 64'(m_tkeep), 64'(bt.keep));
                        check("beat_last", 64'(m_tlast), 64'(bt.last));
                        check("beat_user", 64'(m_tuser), 64'(bt.user));
                        if (m_tuser) abort_gap = cyc - last_beat_cyc;
                        last_beat_cyc = cyc;
                        if (m_tlast) in_frame = 1'b0;
                        nbeats++;
                    end
                end
                if (timeout_err) tmo_pulses++;
            end
            cyc++;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_hdr_valid"}, 64'(m_udp_hdr_valid), 64'd0);
        check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        check({tag, "_dest_ip"}, 64'(m_udp_ip_dest_ip), 64'd0);
        check({tag, "_length"}, 64'(m_udp_length), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : main
        int base, n;
        kill = 1'b0;
        m_udp_hdr_ready = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            hv[i] = 0; tv[i] = 0; tl[i] = 0; tu[i] = 0;
            dip[i] = 0; sp[i] = 0; dp[i] = 0; ln[i] = 0; td[i] = 0; tk[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous requests from rr_ptr=0 are served 0,1,2
        for (int i = 0; i < 3; i++)
            expect_frame(i, 32'hC0A8_0200 + 32'(i), 16'(100 + i), 16'(200 + i), 16'd16, 1, 8'hFF, 16'h2000, 1);
        fork
            send_frame(0, 32'hC0A8_0200, 16'd100, 16'd200, 16'd16, 1, 8'hFF, 16'h2000, -1);
            send_frame(1, 32'hC0A8_0201, 16'd101, 16'd201, 16'd16, 1, 8'hFF, 16'h2000, -1);
            send_frame(2, 32'hC0A8_0202, 16'd102, 16'd202, 16'd16, 1, 8'hFF, 16'h2000, -1);
        join

        // rr_ptr=3 now: requester 3 first, then wrap to 0
        expect_frame(3, 32'hC0A8_0303, 16'd303, 16'd403, 16'd24, 2, 8'h3F, 16'h3000, 2);
        expect_frame(0, 32'hC0A8_0300, 16'd300, 16'd400, 16'd24, 2, 8'h07, 16'h3100, 2);
        fork
            send_frame(3, 32'hC0A8_0303, 16'd303, 16'd403, 16'd24, 2, 8'h3F, 16'h3000, -1);
            send_frame(0, 32'hC0A8_0300, 16'd300, 16'd400, 16'd24, 2, 8'h07, 16'h3100, -1);
        join

        expect_frame(0, 32'hC0A8_0166, 16'd1234, 16'd5678, 16'd32, 3, 8'h0F, 16'h1000, 3);
        send_frame(0, 32'hC0A8_0166, 16'd1234, 16'd5678, 16'd32, 3, 8'h0F, 16'h1000, -1);
        check("t1_grant_idle", 64'(grant), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // Header backpressure, then toggling payload ready
        expect_frame(2, 32'hC0A8_0402, 16'd4000, 16'd4001, 16'd40, 4, 8'hFF, 16'h4000, 4);
        m_udp_hdr_ready = 1'b0;
        fork
            send_frame(2, 32'hC0A8_0402, 16'd4000, 16'd4001, 16'd40, 4, 8'hFF, 16'h4000, -1);
            begin
                n = 0;
                while (!m_udp_hdr_valid && n < 50) begin @(negedge clk); n++; end
                check("t4_hdr_seen", 64'(m_udp_hdr_valid), 64'd1);
                repeat (10) begin
                    @(negedge clk);
                    check("t4_hdr_hold", 64'(m_udp_hdr_valid), 64'd1);
                    check("t4_no_early_beat", 64'(s_tready), 64'd0);
                end
                @(posedge clk); #1;
                m_udp_hdr_ready = 1'b1;
                repeat (16) begin
                    m_tready = ~m_tready;
                    @(posedge clk); #1;
                end
                m_tready = 1'b1;
            end
        join

        // Reset while beat 2 of 4 is presented
        expect_frame(2, 32'hC0A8_0502, 16'd5000, 16'd5001, 16'd40, 4, 8'hFF, 16'h5000, 4);
        base = nbeats;
        fork
            send_frame(2, 32'hC0A8_0502, 16'd5000, 16'd5001, 16'd40, 4, 8'hFF, 16'h5000, -1);
            begin
                n = 0;
                while (nbeats == base && n < 100) begin @(posedge clk); n++; end
                check("t5_first_beat", 64'(nbeats - base), 64'd1);
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_state("t5_async_reset");
                kill = 1'b1;
            end
        join
        hdr_q.delete();
        beat_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        kill = 1'b0;
        @(posedge clk); #1;
        expect_frame(0, 32'hC0A8_0600, 16'd600, 16'd700, 16'd16, 1, 8'hFF, 16'h6000, 1);
        expect_frame(3, 32'hC0A8_0603, 16'd603, 16'd703, 16'd16, 1, 8'hFF, 16'h6300, 1);
        fork
            send_frame(3, 32'hC0A8_0603, 16'd603, 16'd703, 16'd16, 1, 8'hFF, 16'h6300, -1);
            send_frame(0, 32'hC0A8_0600, 16'd600, 16'd700, 16'd16, 1, 8'hFF, 16'h6000, -1);
        join

`ifdef UDP_TX_ARB_WATCHDOG_EN
        expect_frame(1, 32'hC0A8_0701, 16'd7000, 16'd7001, 16'd40, 4, 8'hFF, 16'h7000, 1);
        beat_q.push_back('{data: 64'd0, keep: 8'h01, last: 1'b1, user: 1'b1});
        send_frame(1, 32'hC0A8_0701, 16'd7000, 16'd7001, 16'd40, 4, 8'hFF, 16'h7000, 1);
        check("t6_abort_gap", 64'(abort_gap), 64'(TB_TIMEOUT + 1));
        check("t6_timeout_pulses", 64'(tmo_pulses), 64'd1);
        check("t6_busy_after_drain", 64'(busy), 64'd0);
        check("t6_grant_after_drain", 64'(grant), 64'd0);
`else
        check("no_timeout_pulses", 64'(tmo_pulses), 64'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("hdr_queue_drained", 64'(hdr_q.size()), 64'd0);
        check("beat_queue_drained", 64'(beat_q.size()), 64'd0);
        check("final_busy", 64'(busy), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
